axis_gen_scheduler: RTL and testbench
=====================================

Name: axis_gen_scheduler

Overview:
Control-plane sequencer for the AXI-Stream data generator. Software programs packet length, packet count and inter-packet gap over an AXI4-Lite slave. The block then issues one generator command per packet, waits for each packet to complete, and enforces the gap. It sits between the PS AXI4-Lite interconnect and the generator's command port, and raises an interrupt when a programmed run finishes.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, AXI4-Lite byte address width; 4 registers.
LEN_WIDTH, 16, width of the packet-length field and of cmd_len.

Ports:
ACLK  in  1  single clock for all logic.
ARESET  in  1  synchronous reset, active-high.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  always 2'b00.
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 2'b00.
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
cmd_valid  out  1  generator command valid.
cmd_ready  in  1  generator accepts the command.
cmd_len  out  LEN_WIDTH  words in this packet; stable while cmd_valid is high.
gen_done  in  1  one-cycle pulse when the generator emits TLAST of the current packet.
irq  out  1  level interrupt: run complete. Cleared by W1C.

Behaviour:
- Register map (word-aligned; AWADDR[1:0] and ARADDR[1:0] ignored):
  - 0x0 CTRL: [0] START (self-clearing). [1] CONTINUOUS. [2] ABORT (self-clearing). [31:16] NUM_PKTS.
  - 0x4 PKT_LEN: [15:0]. A value of 0 is issued as 1.
  - 0x8 GAP: [15:0], idle cycles between packets.
  - 0xC STATUS: [15:0] pkts_sent (RO). [16] busy (RO). [17] done (W1C; same bit as irq).
- WSTRB applies per byte to the RW fields.
- Reset values: all registers 0. AWREADY=WREADY=BVALID=ARREADY=RVALID=0, RDATA=0, cmd_valid=0, cmd_len=0, irq=0. FSM state is IDLE.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - The register updates on that same edge.
  - BVALID rises the next cycle and holds until BREADY.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA is registered and RVALID rises the next cycle, holding until RREADY.
  - START and ABORT always read 0.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE -> ISSUE on a START write.
    - pkts_sent clears to 0; busy=1.
    - If NUM_PKTS=0 and CONTINUOUS=0, go straight to done (irq=1, busy=0) with no command issued.
  - ISSUE: cmd_valid=1, cmd_len=max(PKT_LEN,1), latched at ISSUE entry.
    - On cmd_valid & cmd_ready: cmd_valid drops the next cycle and the FSM moves to WAIT.
  - WAIT: on gen_done, pkts_sent increments (saturating at 0xFFFF).
    - If the run is finished (pkts_sent+1 == NUM_PKTS and !CONTINUOUS): go to IDLE, busy=0, done/irq=1.
    - Otherwise, if GAP=0, go directly to ISSUE, so the next cmd_valid appears one cycle after gen_done.
    - Otherwise load the gap counter with GAP and go to GAP.
  - GAP: decrement each cycle; go to ISSUE on the cycle the counter reaches 1. This yields exactly GAP idle cycles between gen_done and the next cmd_valid.
- ABORT:
  - In ISSUE: cmd_valid stays high until the handshake completes (AXIS-style rule: valid is not withdrawn). The FSM then goes to WAIT and finishes that packet.
  - In WAIT: the current packet finishes.
  - After that packet (or immediately in GAP), go to IDLE with done=1.
  - pkts_sent reflects only completed packets.
- START while busy: ignored. Register writes while busy take effect at the next ISSUE entry (PKT_LEN, GAP), except that NUM_PKTS and CONTINUOUS are latched at START.
- gen_done outside WAIT: ignored.
- A CPU W1C of done on the same cycle as a hardware set: the set wins.
- ARESET mid-run: all state returns to reset values on the next edge, including an outstanding BVALID/RVALID and cmd_valid.

Test Plan:
1. PKT_LEN=8, GAP=0, NUM_PKTS=3, START; generator returns cmd_ready=1 and gen_done 8 cycles after each accept -> 3 commands with cmd_len=8, each cmd_valid one cycle after the previous gen_done; STATUS=0x0002_0003 and irq=1; W1C of bit17 -> irq=0, STATUS=0x0000_0003.
2. GAP=5, NUM_PKTS=2 -> exactly 5 cycles between the first gen_done and the second cmd_valid.
3. cmd_ready held low for 10 cycles -> cmd_valid stays high and cmd_len stays stable; the command is accepted on the first cmd_ready cycle.
4. CONTINUOUS=1, then ABORT written while in WAIT after 4 packets -> the 5th packet completes; pkts_sent=5, busy=0, irq=1; no further cmd_valid.
5. Write and read back each register with WSTRB=4'b0011 on PKT_LEN=0xAAAA_5555 over an old value 0 -> reads 0x0000_5555; BREADY held low for 3 cycles -> BVALID held, no second write accepted.
6. ARESET asserted while in GAP with RVALID pending -> next cycle all outputs at reset values; a subsequent START runs normally.

Source files
------------

// File: rtl/axis_gen_scheduler.sv
// axis_gen_scheduler
//   Control-plane sequencer for the AXI-Stream data generator. Software
//   programs packet length, packet count and inter-packet gap through an
//   AXI4-Lite slave. The block then issues one generator command per packet,
//   waits for that packet's gen_done, enforces the programmed gap, and raises
//   irq when the run is over.
//
// Ports
//   ACLK, ARESET           : single clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*        : AXI4-Lite write channels (BRESP always OKAY)
//   S_AXI_AR*/R*           : AXI4-Lite read channels (RRESP always OKAY)
//   cmd_valid/cmd_ready    : generator command handshake
//   cmd_len                : words in the commanded packet, held while valid
//   gen_done               : one-cycle pulse at TLAST of the current packet
//   irq                    : level interrupt, mirrors STATUS.done (W1C)
//
// Register map (word addressed, byte offset bits ignored)
//   0x0 CTRL    [0] START (self-clearing) [1] CONTINUOUS [2] ABORT
//               (self-clearing) [31:16] NUM_PKTS
//   0x4 PKT_LEN [15:0], zero is issued as one
//   0x8 GAP     [15:0], idle cycles between packets
//   0xC STATUS  [15:0] pkts_sent (RO) [16] busy (RO) [17] done (W1C)
module axis_gen_scheduler #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LEN_WIDTH          = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [LEN_WIDTH-1:0]            cmd_len,
  input  logic                            gen_done,
  output logic                            irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_GAP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

  // Byte-strobe merge of a 16-bit register field.
  function automatic logic [15:0] merge16(input logic [15:0] old,
                                          input logic [15:0] data,
                                          input logic [1:0]  strb);
    merge16[7:0]  = strb[0] ? data[7:0]  : old[7:0];
    merge16[15:8] = strb[1] ? data[15:8] : old[15:8];
  endfunction

  // AXI channel state
  logic        aw_w_ready, bvalid, arready, rvalid;
  logic [31:0] rdata, rd_word;
  logic        wr_en, rd_en;
  logic [1:0]  wr_sel;

  // Programmable registers and run state
  logic                 ctrl_cont;
  logic [15:0]          ctrl_num;
  logic [LEN_WIDTH-1:0] pkt_len;
  logic [15:0]          gap_reg, gap_cnt, pkts_sent, pkts_next, run_num;
  logic                 run_cont, busy, done, abort_pend;

  // Decoded write strobes and the CTRL value as it will be after this write
  logic        ctrl_wr, len_wr, gap_wr, start_req, abort_wr, done_clr;
  logic        cont_new;
  logic [15:0] num_new, len_merged;
  logic        run_finished, abort_any;

  // FSM
  state_t state, state_nxt;
  logic   launch, zero_run, count, finish, gap_load, gap_dec, issue_entry;

  assign S_AXI_AWREADY = aw_w_ready;
  assign S_AXI_WREADY  = aw_w_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = done;

  assign wr_en  = aw_w_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en  = arready & S_AXI_ARVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];

  assign ctrl_wr    = wr_en & (wr_sel == REG_CTRL);
  assign len_wr     = wr_en & (wr_sel == REG_LEN);
  assign gap_wr     = wr_en & (wr_sel == REG_GAP);
  assign start_req  = ctrl_wr & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign abort_wr   = ctrl_wr & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
  assign done_clr   = wr_en & (wr_sel == REG_STATUS) & S_AXI_WSTRB[2] & S_AXI_WDATA[17];
  assign cont_new   = (ctrl_wr & S_AXI_WSTRB[0]) ? S_AXI_WDATA[1] : ctrl_cont;
  assign num_new    = ctrl_wr ? merge16(ctrl_num, S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2])
                              : ctrl_num;
  assign len_merged = merge16(16'(pkt_len), S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);

  assign pkts_next    = (pkts_sent == 16'hFFFF) ? pkts_sent : pkts_sent + 16'd1;
  // 17-bit compare so a saturated counter never wraps into a false match.
  assign run_finished = ({1'b0, pkts_sent} + 17'd1 == {1'b0, run_num}) & ~run_cont;
  assign abort_any    = abort_pend | abort_wr;
  assign issue_entry  = (state_nxt == ST_ISSUE) & (state != ST_ISSUE);

  // Byte offset bits are intentionally don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Read-data mux; START and ABORT always read back as zero.
  always_comb begin
    rd_word = 32'd0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:   rd_word = {ctrl_num, 13'd0, 1'b0, ctrl_cont, 1'b0};
      REG_LEN:    rd_word = 32'(pkt_len);
      REG_GAP:    rd_word = {16'd0, gap_reg};
      REG_STATUS: rd_word = {14'd0, done, busy, pkts_sent};
      default:    rd_word = 32'd0;
    endcase
  end

  // AXI4-Lite handshakes: one-cycle ready pulses, response held until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_w_ready <= 1'b0;
      bvalid     <= 1'b0;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= 32'd0;
    end else begin
      aw_w_ready <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~aw_w_ready;
      if (wr_en) begin
        bvalid <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      arready <= S_AXI_ARVALID & ~rvalid & ~arready;
      if (rd_en) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    zero_run  = 1'b0;
    count     = 1'b0;
    finish    = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          launch = 1'b1;
          if ((num_new == 16'd0) && !cont_new) begin
            zero_run = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Valid is never withdrawn, even on abort, until the handshake.
        if (cmd_valid && cmd_ready) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (gen_done) begin
          count = 1'b1;
          if (run_finished || abort_any) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else if (gap_reg == 16'd0) begin
            state_nxt = ST_ISSUE;
          end else begin
            gap_load  = 1'b1;
            state_nxt = ST_GAP;
          end
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (abort_any) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (gap_cnt <= 16'd1) begin
          state_nxt = ST_ISSUE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register file, run bookkeeping and the registered command outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_cont  <= 1'b0;
      ctrl_num   <= 16'd0;
      pkt_len    <= '0;
      gap_reg    <= 16'd0;
      gap_cnt    <= 16'd0;
      pkts_sent  <= 16'd0;
      run_num    <= 16'd0;
      run_cont   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_len    <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_cont <= cont_new;
        ctrl_num  <= num_new;
      end
      if (len_wr) begin
        pkt_len <= len_merged[LEN_WIDTH-1:0];
      end
      if (gap_wr) begin
        gap_reg <= merge16(gap_reg, S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);
      end
      // Count and mode are frozen for the run at START.
      if (launch) begin
        pkts_sent <= 16'd0;
        run_num   <= num_new;
        run_cont  <= cont_new;
      end else if (count) begin
        pkts_sent <= pkts_next;
      end
      if (zero_run || finish) begin
        busy <= 1'b0;
      end else if (launch) begin
        busy <= 1'b1;
      end
      // Hardware set has priority over a simultaneous W1C.
      if (zero_run || finish) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
      if (state_nxt == ST_IDLE) begin
        abort_pend <= 1'b0;
      end else if (abort_wr && (state != ST_IDLE)) begin
        abort_pend <= 1'b1;
      end
      if (gap_load) begin
        gap_cnt <= gap_reg;
      end else if (gap_dec) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
      cmd_valid <= (state_nxt == ST_ISSUE);
      if (issue_entry) begin
        cmd_len <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
      end
    end
  end

endmodule

// File: tb/tb_axis_gen_scheduler.sv
// Self-checking bench for axis_gen_scheduler. A generator model accepts
// commands, returns gen_done 8 cycles after each accept, and logs command
// timing; expected command lengths are queued when a run is programmed and
// popped against the logged accepts.
module tb_axis_gen_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = 4'd0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = 32'd0;
  logic [3:0]  S_AXI_WSTRB = 4'd0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = 4'd0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [15:0] cmd_len;
  logic        gen_done = 1'b0;
  logic        irq;

  axis_gen_scheduler #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .LEN_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .gen_done(gen_done), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Generator-model logs and scoreboard
  int          rise_q[$], acc_q[$], done_q[$];
  logic [15:0] acc_len_q[$], exp_len_q[$];
  int          stall_cfg = 0;
  int          drop_err = 0, len_err = 0;

  // Generator model: drives cmd_ready/gen_done on the falling edge.
  initial begin : gen_model
    int          timer;
    int          stall;
    logic        prev_v, prev_acc;
    logic [15:0] held_len;
    timer = 0; stall = 0; prev_v = 1'b0; prev_acc = 1'b0; held_len = 16'd0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        timer = 0; stall = 0; gen_done = 1'b0; cmd_ready = 1'b1;
        prev_v = 1'b0; prev_acc = 1'b0;
      end else begin
        gen_done = 1'b0;
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            gen_done = 1'b1;
            done_q.push_back(cyc);
          end
        end
        if (cmd_valid && !prev_v) begin
          rise_q.push_back(cyc);
          held_len = cmd_len;
          stall = stall_cfg;
        end
        if (prev_v && !cmd_valid && !prev_acc) drop_err++;
        if (cmd_valid && (cmd_len !== held_len)) len_err++;
        if (stall > 0) begin
          cmd_ready = 1'b0;
          stall--;
        end else begin
          cmd_ready = 1'b1;
        end
        prev_acc = cmd_valid && cmd_ready;
        if (prev_acc) begin
          acc_q.push_back(cyc);
          acc_len_q.push_back(cmd_len);
          timer = 8;
        end
        prev_v = cmd_valid;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    rise_q.delete(); acc_q.delete(); done_q.delete();
    acc_len_q.delete(); exp_len_q.delete();
    drop_err = 0; len_err = 0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (!S_AXI_BVALID && n < 40) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL axi_write_timeout addr=%h got no handshake, required one within 20 cycles", a);
    end
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && n < 40) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL axi_read_timeout addr=%h got no response, required one within 20 cycles", a);
    end
    d = S_AXI_RDATA;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, cmd_valid, irq} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl_outputs got %b required 0000000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, cmd_valid, irq});
    end
    vectors++;
    if (S_AXI_RDATA !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h required 0", S_AXI_RDATA); end
    vectors++;
    if (cmd_len !== 16'd0) begin miscompares++; $display("FAIL reset_cmd_len got %h required 0", cmd_len); end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      vectors++;
      if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_reg%0d got %h required 0", i, rd); end
    end
  endtask

  task automatic test_single_run();
    logic [31:0] rd;
    logic [15:0] e, g;
    int n;
    clear_logs();
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h8, 32'd0, 4'hF);
    repeat (3) exp_len_q.push_back(16'd8);
    axi_write(4'h0, 32'h0003_0001, 4'hF);
    n = 0;
    while (done_q.size() < 3 && n < 400) begin @(negedge ACLK); n++; end
    vectors++;
    if (done_q.size() < 3) begin miscompares++; $display("FAIL run1_wait got %0d packets required 3", done_q.size()); end
    repeat (3) @(negedge ACLK);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL run1_irq got %b required 1", irq); end
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0002_0003) begin miscompares++; $display("FAIL run1_status got %h required 00020003", rd); end
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (rise_q.size() <= i || done_q.size() < i) begin
        miscompares++; $display("FAIL run1_spacing%0d missing events", i);
      end else if (rise_q[i] - done_q[i-1] != 1) begin
        miscompares++; $display("FAIL run1_spacing%0d got %0d cycles required 1", i, rise_q[i] - done_q[i-1]);
      end
    end
    while (exp_len_q.size() > 0) begin
      e = exp_len_q.pop_front();
      vectors++;
      if (acc_len_q.size() == 0) begin miscompares++; $display("FAIL run1_len missing, required %0d", e); end
      else begin
        g = acc_len_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL run1_len got %0d required %0d", g, e); end
      end
    end
    vectors++;
    if (acc_len_q.size() != 0) begin miscompares++; $display("FAIL run1_extra got %0d extra commands required 0", acc_len_q.size()); end
    axi_write(4'hC, 32'h0002_0000, 4'b0100);
    @(negedge ACLK);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL run1_w1c_irq got %b required 0", irq); end
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0000_0003) begin miscompares++; $display("FAIL run1_w1c_status got %h required 00000003", rd); end
  endtask

  task automatic test_gap();
    logic [15:0] e, g;
    int n;
    clear_logs();
    axi_write(4'h4, 32'd4, 4'hF);
    axi_write(4'h8, 32'd5, 4'hF);
    repeat (2) exp_len_q.push_back(16'd4);
    axi_write(4'h0, 32'h0002_0001, 4'hF);
    n = 0;
    while (done_q.size() < 2 && n < 400) begin @(negedge ACLK); n++; end
    vectors++;
    if (done_q.size() < 2 || rise_q.size() < 2) begin
      miscompares++; $display("FAIL gap_wait got %0d packets required 2", done_q.size());
    end else if (rise_q[1] - done_q[0] != 6) begin
      miscompares++; $display("FAIL gap_idle got %0d idle cycles required 5", rise_q[1] - done_q[0] - 1);
    end
    while (exp_len_q.size() > 0) begin
      e = exp_len_q.pop_front();
      vectors++;
      if (acc_len_q.size() == 0) begin miscompares++; $display("FAIL gap_len missing, required %0d", e); end
      else begin
        g = acc_len_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL gap_len got %0d required %0d", g, e); end
      end
    end
    repeat (3) @(negedge ACLK);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL gap_irq got %b required 1", irq); end
    axi_write(4'hC, 32'h0002_0000, 4'b0100);
  endtask

  task automatic test_stall_and_zero_len();
    logic [15:0] e, g;
    int n;
    clear_logs();
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h8, 32'd0, 4'hF);
    stall_cfg = 10;
    exp_len_q.push_back(16'd1);
    axi_write(4'h0, 32'h0001_0001, 4'hF);
    n = 0;
    while (done_q.size() < 1 && n < 400) begin @(negedge ACLK); n++; end
    stall_cfg = 0;
    vectors++;
    if (acc_q.size() < 1 || rise_q.size() < 1) begin
      miscompares++; $display("FAIL stall_wait got no accepted command, required 1");
    end else if (acc_q[0] - rise_q[0] != 10) begin
      miscompares++; $display("FAIL stall_accept got %0d cycles after valid required 10", acc_q[0] - rise_q[0]);
    end
    vectors++;
    if (drop_err != 0 || len_err != 0) begin
      miscompares++; $display("FAIL stall_hold got %0d drops %0d len changes required 0 0", drop_err, len_err);
    end
    while (exp_len_q.size() > 0) begin
      e = exp_len_q.pop_front();
      vectors++;
      if (acc_len_q.size() == 0) begin miscompares++; $display("FAIL zero_len missing, required %0d", e); end
      else begin
        g = acc_len_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL zero_len got %0d required %0d", g, e); end
      end
    end
    repeat (3) @(negedge ACLK);
    axi_write(4'hC, 32'h0002_0000, 4'b0100);
  endtask

  task automatic test_zero_pkts();
    logic [31:0] rd;
    clear_logs();
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    @(negedge ACLK);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL zero_pkts_irq got %b required 1", irq); end
    repeat (20) @(negedge ACLK);
    vectors++;
    if (rise_q.size() != 0) begin miscompares++; $display("FAIL zero_pkts_cmds got %0d required 0", rise_q.size()); end
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0002_0000) begin miscompares++; $display("FAIL zero_pkts_status got %h required 00020000", rd); end
    axi_write(4'hC, 32'h0002_0000, 4'b0100);
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic [15:0] e, g;
    int n;
    clear_logs();
    axi_write(4'h4, 32'd2, 4'hF);
    repeat (5) exp_len_q.push_back(16'd2);
    axi_write(4'h0, 32'h0000_0003, 4'hF);
    n = 0;
    while (acc_q.size() < 5 && n < 600) begin @(negedge ACLK); n++; end
    axi_write(4'h0, 32'h0000_0006, 4'b0001);
    n = 0;
    while (!irq && n < 100) begin @(negedge ACLK); n++; end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL abort_irq got %b required 1", irq); end
    repeat (30) @(negedge ACLK);
    vectors++;
    if (rise_q.size() != 5 || done_q.size() != 5) begin
      miscompares++; $display("FAIL abort_count got %0d cmds %0d done required 5 5", rise_q.size(), done_q.size());
    end
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0002_0005) begin miscompares++; $display("FAIL abort_status got %h required 00020005", rd); end
    while (exp_len_q.size() > 0) begin
      e = exp_len_q.pop_front();
      vectors++;
      if (acc_len_q.size() == 0) begin miscompares++; $display("FAIL abort_len missing, required %0d", e); end
      else begin
        g = acc_len_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL abort_len got %0d required %0d", g, e); end
      end
    end
    axi_write(4'h0, 32'd0, 4'hF);
    axi_write(4'hC, 32'h0002_0000, 4'b0100);
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    int n;
    axi_write(4'h4, 32'd0, 4'hF);
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hAAAA_5555; S_AXI_WSTRB = 4'b0011;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_WDATA = 32'h1111_2222; S_AXI_WSTRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
        miscompares++; $display("FAIL bhold_cycle%0d got bvalid=%b awready=%b required 1 0", i, S_AXI_BVALID, S_AXI_AWREADY);
      end
      if (i < 2) @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    vectors++;
    if (S_AXI_BVALID !== 1'b0) begin miscompares++; $display("FAIL bready_release got %b required 0", S_AXI_BVALID); end
    axi_read(4'h4, rd);
    vectors++;
    if (rd !== 32'h0000_5555) begin miscompares++; $display("FAIL strb_pkt_len got %h required 00005555", rd); end
    axi_write(4'h8, 32'h0000_0007, 4'hF);
    axi_read(4'h8, rd);
    vectors++;
    if (rd !== 32'h0000_0007) begin miscompares++; $display("FAIL gap_rw got %h required 00000007", rd); end
    axi_write(4'h0, 32'h0005_0006, 4'hF);
    axi_read(4'h0, rd);
    vectors++;
    if (rd !== 32'h0005_0002) begin miscompares++; $display("FAIL ctrl_rw got %h required 00050002", rd); end
    axi_write(4'h0, 32'd0, 4'hF);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b1011);
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0000_0005) begin miscompares++; $display("FAIL status_ro got %h required 00000005", rd); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    logic [15:0] g;
    int n;
    clear_logs();
    axi_write(4'h4, 32'd3, 4'hF);
    axi_write(4'h8, 32'd20, 4'hF);
    axi_write(4'h0, 32'h0002_0001, 4'hF);
    n = 0;
    while (done_q.size() < 1 && n < 200) begin @(negedge ACLK); n++; end
    repeat (2) @(negedge ACLK);
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    vectors++;
    if (S_AXI_RVALID !== 1'b1) begin miscompares++; $display("FAIL midrst_rvalid_pending got %b required 1", S_AXI_RVALID); end
    ARESET = 1'b1;
    @(negedge ACLK);
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, cmd_valid, irq} !== 7'd0
        || S_AXI_RDATA !== 32'd0 || cmd_len !== 16'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs got ctl=%b rdata=%h len=%h required 0 0 0",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, cmd_valid, irq},
               S_AXI_RDATA, cmd_len);
    end
    ARESET = 1'b0;
    repeat (40) @(negedge ACLK);
    vectors++;
    if (rise_q.size() != 1) begin miscompares++; $display("FAIL midrst_idle got %0d cmds required 1", rise_q.size()); end
    clear_logs();
    axi_write(4'h4, 32'd3, 4'hF);
    exp_len_q.push_back(16'd3);
    axi_write(4'h0, 32'h0001_0001, 4'hF);
    n = 0;
    while (done_q.size() < 1 && n < 200) begin @(negedge ACLK); n++; end
    repeat (3) @(negedge ACLK);
    vectors++;
    if (acc_len_q.size() != 1) begin miscompares++; $display("FAIL midrst_rerun_cmds got %0d required 1", acc_len_q.size()); end
    else begin
      g = acc_len_q.pop_front();
      if (g !== exp_len_q.pop_front()) begin miscompares++; $display("FAIL midrst_rerun_len got %0d required 3", g); end
    end
    axi_read(4'hC, rd);
    vectors++;
    if (rd !== 32'h0002_0001) begin miscompares++; $display("FAIL midrst_rerun_status got %h required 00020001", rd); end
  endtask

  initial begin : main
    test_reset();
    test_single_run();
    test_gap();
    test_stall_and_zero_len();
    test_zero_pkts();
    test_abort();
    test_regs();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
